// File: rtl/k051937_draw_sched.sv
// k051937_draw_sched: per-line sprite draw scheduler feeding the k051937 render port.
// Latches each admitted entry (LACH/HP/OC/OHF), then streams its pixel pairs on CARY within a line budget.
module k051937_draw_sched #(
   parameter int BUDGET    = 640,
   parameter int SETUP_LAT = 3,
   parameter int GAP       = 1
) (
   input  logic       clk_24M,
   input  logic       nRES,
   input  logic       cen_12M,
   input  logic       new_line,
   input  logic       spr_valid,
   output logic       spr_ready,
   input  logic [8:0] spr_x,
   input  logic [7:0] spr_pal,
   input  logic       spr_flip,
   input  logic [1:0] spr_sz,
   input  logic       spr_last,
   output logic       LACH,
   output logic [8:0] HP,
   output logic [7:0] OC,
   output logic       OHF,
   output logic       CARY,
   output logic       HEND,
   output logic       busy,
   output logic [7:0] line_drops
);
   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETUP, S_DRAW, S_GAP, S_DONE} state_t;
   state_t      state_q, state_d;
   logic [1:0]  rst_sync_q, rst_sync_d;
   logic        rst_n_i;
   logic [9:0]  bud_q, bud_d, need;
   logic [7:0]  drops_q, drops_d, oc_q, oc_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [8:0]  hp_q, hp_d;
   logic [1:0]  sz_q, sz_d;
   logic        ohf_q, ohf_d, last_q, last_d, fits, take;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n_i    = rst_sync_q[1];

   always_ff @(posedge clk_24M or negedge nRES)
      if (!nRES) rst_sync_q <= 2'b00;
      else       rst_sync_q <= rst_sync_d;

   assign need       = 10'(1 + SETUP_LAT + GAP) + (10'd8 << spr_sz);
   assign fits       = need <= bud_q;
   // an entry offered alongside new_line is left for the following cen cycle
   assign take       = cen_12M & ~new_line & (state_q == S_LATCH) & (bud_q != 10'd0) & spr_valid;
   assign spr_ready  = take;
   assign LACH       = take & fits;
   assign HP         = LACH ? spr_x : hp_q;
   assign OC         = LACH ? spr_pal : oc_q;
   assign OHF        = LACH ? spr_flip : ohf_q;
   assign CARY       = (state_q == S_DRAW) & ~(cen_12M & new_line);
   assign HEND       = state_q == S_DONE;
   assign busy       = (state_q != S_IDLE) & (state_q != S_DONE);
   assign line_drops = drops_q;

   always_comb begin
      state_d = state_q;
      bud_d   = bud_q;
      drops_d = drops_q;
      cnt_d   = cnt_q;
      hp_d    = hp_q;
      oc_d    = oc_q;
      ohf_d   = ohf_q;
      sz_d    = sz_q;
      last_d  = last_q;
      if (cen_12M) begin
         bud_d = busy ? bud_q - 10'(bud_q != 10'd0) : bud_q;
         if (new_line) begin
            state_d = S_LATCH;
            bud_d   = 10'(BUDGET);
            drops_d = 8'd0;
         end else begin
            case (state_q)
               S_LATCH:
                  if (bud_q == 10'd0) state_d = S_DONE;
                  else if (spr_valid && fits) begin
                     hp_d    = spr_x;
                     oc_d    = spr_pal;
                     ohf_d   = spr_flip;
                     sz_d    = spr_sz;
                     last_d  = spr_last;
                     cnt_d   = 7'(SETUP_LAT - 2);
                     state_d = S_SETUP;
                  end else if (spr_valid) begin
                     drops_d = drops_q + 8'(drops_q != 8'hff);
                     state_d = spr_last ? S_DONE : S_LATCH;
                  end
               S_SETUP: begin
                  cnt_d   = (cnt_q == 7'd0) ? (7'd8 << sz_q) - 7'd1 : cnt_q - 7'd1;
                  state_d = (cnt_q == 7'd0) ? S_DRAW : S_SETUP;
               end
               S_DRAW: begin
                  cnt_d   = (cnt_q == 7'd0) ? 7'(GAP - 1) : cnt_q - 7'd1;
                  state_d = (cnt_q == 7'd0) ? S_GAP : S_DRAW;
               end
               S_GAP: begin
                  cnt_d   = cnt_q - 7'd1;
                  state_d = (cnt_q != 7'd0) ? S_GAP : last_q ? S_DONE : S_LATCH;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_24M or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         bud_q   <= 10'(BUDGET);
         drops_q <= 8'd0;
         cnt_q   <= 7'd0;
         hp_q    <= 9'd0;
         oc_q    <= 8'd0;
         ohf_q   <= 1'b0;
         sz_q    <= 2'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bud_q   <= bud_d;
         drops_q <= drops_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         oc_q    <= oc_d;
         ohf_q   <= ohf_d;
         sz_q    <= sz_d;
         last_q  <= last_d;
      end
endmodule

// File: tb/tb_k051937_draw_sched.sv
// tb_k051937_draw_sched: directed bench for the sprite draw scheduler.
// Two instances share stimulus: default budget (640) and a reduced budget (40).
module tb_k051937_draw_sched;
   logic clk = 0, nRES = 0, cen = 1, nl = 0, v = 0, fl = 0, last = 0;
   logic [8:0] x = 0;
   logic [7:0] pal = 0;
   logic [1:0] sz = 0;
   logic       a_rdy, a_lach, a_ohf, a_cary, a_hend, a_busy, b_rdy, b_lach, b_ohf, b_cary, b_hend, b_busy;
   logic [8:0] a_hp, b_hp;
   logic [7:0] a_oc, a_drops, b_oc, b_drops;
   int n_tests = 0, n_fail = 0;

   k051937_draw_sched dut (
      .clk_24M(clk), .nRES(nRES), .cen_12M(cen), .new_line(nl), .spr_valid(v), .spr_ready(a_rdy),
      .spr_x(x), .spr_pal(pal), .spr_flip(fl), .spr_sz(sz), .spr_last(last), .LACH(a_lach), .HP(a_hp),
      .OC(a_oc), .OHF(a_ohf), .CARY(a_cary), .HEND(a_hend), .busy(a_busy), .line_drops(a_drops));

   k051937_draw_sched #(.BUDGET(40)) dut40 (
      .clk_24M(clk), .nRES(nRES), .cen_12M(cen), .new_line(nl), .spr_valid(v), .spr_ready(b_rdy),
      .spr_x(x), .spr_pal(pal), .spr_flip(fl), .spr_sz(sz), .spr_last(last), .LACH(b_lach), .HP(b_hp),
      .OC(b_oc), .OHF(b_ohf), .CARY(b_cary), .HEND(b_hend), .busy(b_busy), .line_drops(b_drops));

   always #5 clk = ~clk;

   typedef struct {
      logic       nl, v;
      logic [8:0] x;
      logic [7:0] pal;
      logic [20:0] exp;
   } vec_t;
   vec_t tv[16];

   logic [8:0] ex[4], hp_l[4];
   logic [7:0] ep[4], oc_l[4];
   logic       ef[4], el[4], ohf_l[4];
   logic [1:0] es[4];
   int lach_cnt, lach_c[4], cary_cnt, hend_c, rdy_cnt, ptr;
   logic cary_nl, lach_nl, hend_a, cary_a, busy_a;
   logic [7:0] drops_nl, drops_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_line(input int n_ent, input int ncyc, input bit use40, input int nl2);
      logic l, cy, h, r, bz, o;
      logic [8:0] hp;
      logic [7:0] oc, dr;
      lach_cnt = 0; cary_cnt = 0; hend_c = -1; rdy_cnt = 0; ptr = 0;
      for (int c = 0; c < ncyc; c++) begin
         nl = (c == 0) || (c == nl2);
         v  = ptr < n_ent;
         if (v) begin
            x = ex[ptr]; pal = ep[ptr]; fl = ef[ptr]; sz = es[ptr]; last = el[ptr];
         end else begin
            x = 0; pal = 0; fl = 0; sz = 0; last = 0;
         end
         @(negedge clk);
         l  = use40 ? b_lach : a_lach;
         cy = use40 ? b_cary : a_cary;
         h  = use40 ? b_hend : a_hend;
         r  = use40 ? b_rdy : a_rdy;
         bz = use40 ? b_busy : a_busy;
         o  = use40 ? b_ohf : a_ohf;
         hp = use40 ? b_hp : a_hp;
         oc = use40 ? b_oc : a_oc;
         dr = use40 ? b_drops : a_drops;
         if (l && lach_cnt < 4) begin
            lach_c[lach_cnt] = c; hp_l[lach_cnt] = hp; oc_l[lach_cnt] = oc; ohf_l[lach_cnt] = o;
            lach_cnt++;
         end
         if (cy) cary_cnt++;
         if (h && hend_c < 0 && c > 0) hend_c = c;
         if (r) begin rdy_cnt++; ptr++; end
         if (c == nl2) begin cary_nl = cy; lach_nl = l; drops_nl = dr; end
         if (c == nl2 + 1) begin hend_a = h; drops_a = dr; cary_a = cy; busy_a = bz; end
         @(posedge clk); #1;
      end
      nl = 0; v = 0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tv[i].nl  = (i == 0);
         tv[i].v   = (i < 2);
         tv[i].x   = (i < 2) ? 9'h040 : 9'h000;
         tv[i].pal = (i < 2) ? 8'h15 : 8'h00;
         tv[i].exp = {i == 1, i >= 4 && i <= 11, i >= 13, i == 1,
                      (i >= 1) ? 9'h040 : 9'h000, (i >= 1) ? 8'h15 : 8'h00};
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_a", {a_rdy, a_lach, a_hp, a_oc, a_ohf, a_cary, a_hend, a_busy, a_drops}, 0);
      chk("reset_b", {b_rdy, b_lach, b_hp, b_oc, b_ohf, b_cary, b_hend, b_busy, b_drops}, 0);
      nRES = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_release", {a_rdy, a_lach, a_cary, a_hend, a_busy}, 0);

      // single sz=0 entry, cycle-by-cycle
      for (int i = 0; i < 16; i++) begin
         nl = tv[i].nl; v = tv[i].v; x = tv[i].x; pal = tv[i].pal; fl = 0; sz = 0; last = 1;
         @(negedge clk);
         chk($sformatf("t1_cyc%0d", i), {a_lach, a_cary, a_hend, a_rdy, a_hp, a_oc}, tv[i].exp);
         @(posedge clk); #1;
      end
      v = 0; nl = 0;

      // back-to-back sz=0 then sz=1
      ex[0] = 9'h010; ep[0] = 8'h01; ef[0] = 0; es[0] = 0; el[0] = 0;
      ex[1] = 9'h1ff; ep[1] = 8'haa; ef[1] = 1; es[1] = 1; el[1] = 1;
      run_line(2, 40, 0, -5);
      chk("t2_lach_cnt", lach_cnt, 2);
      chk("t2_lach0", lach_c[0], 1);
      chk("t2_lach1", lach_c[1], 13);
      chk("t2_fields1", {hp_l[1], oc_l[1], ohf_l[1]}, {9'h1ff, 8'haa, 1'b1});
      chk("t2_cary", cary_cnt, 24);
      chk("t2_hend", hend_c, 33);
      chk("t2_rdy", rdy_cnt, 2);

      // budget 40: only the first sz=1 entry fits
      for (int i = 0; i < 3; i++) begin
         ex[i] = 9'(i + 1); ep[i] = 8'(i); ef[i] = 0; es[i] = 1; el[i] = (i == 2);
      end
      run_line(3, 30, 1, -5);
      chk("t3_lach_cnt", lach_cnt, 1);
      chk("t3_rdy", rdy_cnt, 3);
      chk("t3_cary", cary_cnt, 16);
      chk("t3_hend", hend_c, 23);
      chk("t3_drops", b_drops, 2);

      // new_line on the 4th CARY cycle aborts the entry in flight
      ex[0] = 9'h001; ep[0] = 8'h11; ef[0] = 0; es[0] = 3; el[0] = 0;
      ex[1] = 9'h0aa; ep[1] = 8'h22; ef[1] = 0; es[1] = 0; el[1] = 0;
      ex[2] = 9'h155; ep[2] = 8'h3c; ef[2] = 1; es[2] = 0; el[2] = 1;
      run_line(3, 25, 1, 8);
      chk("t4_drops_before", drops_nl, 1);
      chk("t4_cary_at_nl", cary_nl, 0);
      chk("t4_lach_at_nl", lach_nl, 0);
      chk("t4_after", {hend_a, cary_a, busy_a, drops_a}, {1'b0, 1'b0, 1'b1, 8'd0});
      chk("t4_lach_cnt", lach_cnt, 2);
      chk("t4_lach0", lach_c[0], 2);
      chk("t4_lach1", lach_c[1], 9);
      chk("t4_hp1", {hp_l[1], oc_l[1], ohf_l[1]}, {9'h155, 8'h3c, 1'b1});
      chk("t4_cary", cary_cnt, 11);
      chk("t4_hend", hend_c, 21);
      chk("t4_rdy", rdy_cnt, 3);

      // no entries: the budget drains to zero
      run_line(0, 660, 0, -5);
      chk("t5_hend", hend_c, 642);
      chk("t5_lach", lach_cnt, 0);
      chk("t5_rdy", rdy_cnt, 0);

      // reset pulse mid-DRAW
      ex[0] = 9'h123; ep[0] = 8'h5a; ef[0] = 1; es[0] = 3; el[0] = 1;
      run_line(1, 10, 0, -5);
      chk("t6_mid_draw", a_cary, 1);
      #2 nRES = 0;
      #1 chk("t6_reset_now", {a_rdy, a_lach, a_hp, a_oc, a_ohf, a_cary, a_hend, a_busy, a_drops}, 0);
      repeat (2) @(posedge clk);
      #1 nRES = 1;
      x = 9'h0f0; pal = 8'h0f; sz = 0; last = 1; v = 1;
      cary_cnt = 0; lach_cnt = 0; rdy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (a_cary) cary_cnt++;
         if (a_lach) lach_cnt++;
         if (a_rdy || a_busy) rdy_cnt++;
         @(posedge clk); #1;
      end
      v = 0;
      chk("t6_no_cary", cary_cnt, 0);
      chk("t6_no_lach", lach_cnt, 0);
      chk("t6_idle", rdy_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
